jtag_dtm_dr_ctrl: RTL and testbench



---
 rtl/jtag_dtm_pkg.sv | 28 ++
 rtl/jtag_dtm_dmi_fsm.sv | 82 ++++++++
 rtl/jtag_dtm_dr_ctrl.sv | 132 +++++++++++++
 tb/tb_jtag_dtm_dr_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_dtm_pkg.sv
// Shared constants and types for the JTAG debug transport: IR codes, DMI op/status
// encodings, DTMCS version and the DMI handshake state enum.
package jtag_dtm_pkg;

  localparam logic [4:0] IR_DTMCS_DEF = 5'h10;
  localparam logic [4:0] IR_DMI_DEF   = 5'h11;

  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;

  localparam logic [1:0] DMI_RSP_OK     = 2'd0;
  localparam logic [1:0] DMI_RSP_FAILED = 2'd2;
  localparam logic [1:0] DMI_RSP_BUSY   = 2'd3;

  localparam logic [3:0] DTMCS_VERSION = 4'd1;

  typedef enum logic [1:0] {
    DMI_IDLE = 2'd0,
    DMI_REQ  = 2'd1,
    DMI_WAIT = 2'd2
  } dmi_state_e;

  function automatic logic dmi_op_is_access(input logic [1:0] op);
    return (op == DMI_OP_READ) || (op == DMI_OP_WRITE);
  endfunction

endpackage

// File: rtl/jtag_dtm_dmi_fsm.sv
// DMI request tracker (IDLE -> REQ -> WAIT); valid is a registered state decode, the
// request is held until ready, and only a DTM hard reset or TRSTn can drop it early.
module jtag_dtm_dmi_fsm
  import jtag_dtm_pkg::*;
#(
  parameter int ABITS = 7
) (
  input  logic             TCLK,
  input  logic             TRSTn,
  input  logic             start,
  input  logic [ABITS-1:0] start_addr,
  input  logic [31:0]      start_data,
  input  logic [1:0]       start_op,
  input  logic             hard_reset,
  output logic             busy,
  output logic             rsp_take,
  output logic             dmi_req_valid,
  input  logic             dmi_req_ready,
  output logic [ABITS-1:0] dmi_req_addr,
  output logic [31:0]      dmi_req_data,
  output logic [1:0]       dmi_req_op,
  input  logic             dmi_rsp_valid
);

  dmi_state_e state_q, state_d;

  always_ff @(posedge TCLK or negedge TRSTn) begin
    if (!TRSTn) begin
      state_q <= DMI_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rsp_take = 1'b0;
    if (hard_reset) begin
      state_d = DMI_IDLE;
    end else begin
      case (state_q)
        DMI_IDLE: begin
          if (start) state_d = DMI_REQ;
        end
        DMI_REQ: begin
          // A response coincident with acceptance completes the transaction at once.
          if (dmi_req_ready) begin
            if (dmi_rsp_valid) begin
              state_d  = DMI_IDLE;
              rsp_take = 1'b1;
            end else begin
              state_d = DMI_WAIT;
            end
          end
        end
        DMI_WAIT: begin
          if (dmi_rsp_valid) begin
            state_d  = DMI_IDLE;
            rsp_take = 1'b1;
          end
        end
        default: state_d = DMI_IDLE;
      endcase
    end
  end

  always_ff @(posedge TCLK or negedge TRSTn) begin
    if (!TRSTn) begin
      dmi_req_addr <= '0;
      dmi_req_data <= '0;
      dmi_req_op   <= '0;
    end else if (start && (state_q == DMI_IDLE) && !hard_reset) begin
      dmi_req_addr <= start_addr;
      dmi_req_data <= start_data;
      dmi_req_op   <= start_op;
    end
  end

  assign dmi_req_valid = (state_q == DMI_REQ);
  assign busy          = (state_q != DMI_IDLE);

endmodule

// File: rtl/jtag_dtm_dr_ctrl.sv
// DTM data-register controller: decodes IR, owns the shared DTMCS/DMI shift register and
// launches one DMI request per accepted update; the DMI side honours valid/ready.
module jtag_dtm_dr_ctrl
  import jtag_dtm_pkg::*;
#(
  parameter int                  IR_WIDTH  = 5,
  parameter int                  ABITS     = 7,
  parameter logic [IR_WIDTH-1:0] DTMCS_IR  = IR_WIDTH'(IR_DTMCS_DEF),
  parameter logic [IR_WIDTH-1:0] DMI_IR    = IR_WIDTH'(IR_DMI_DEF),
  parameter int                  IDLE_HINT = 1
) (
  input  logic                TCLK,
  input  logic                TRSTn,
  input  logic [IR_WIDTH-1:0] ir,
  input  logic                dr_capture,
  input  logic                dr_shift,
  input  logic                dr_update,
  input  logic                TDI,
  output logic                dr_tdo,
  output logic                dmi_req_valid,
  input  logic                dmi_req_ready,
  output logic [ABITS-1:0]    dmi_req_addr,
  output logic [31:0]         dmi_req_data,
  output logic [1:0]          dmi_req_op,
  input  logic                dmi_rsp_valid,
  input  logic [31:0]         dmi_rsp_data,
  input  logic [1:0]          dmi_rsp_op,
  output logic                dmi_hard_reset
);

  localparam int SRW = ABITS + 34;

  logic [SRW-1:0]   sr_q, sr_d;
  logic [1:0]       dmistat_q;
  logic [ABITS-1:0] last_addr_q;
  logic [31:0]      rsp_data_q;
  logic [31:0]      dtmcs_cap;
  logic [1:0]       op_field;
  logic             sel_cs, sel_dmi;
  logic             upd_cs, upd_dmi;
  logic             hard_rst_req, dmi_reset_req;
  logic             dmi_start;
  logic             busy, rsp_take;
  logic [ABITS-1:0] dr_addr;
  logic [31:0]      dr_data;
  logic [1:0]       dr_op;

  assign sel_cs  = (ir == DTMCS_IR);
  assign sel_dmi = (ir == DMI_IR);
  assign upd_cs  = sel_cs & dr_update;
  assign upd_dmi = sel_dmi & dr_update;

  assign dr_addr = sr_q[SRW-1:34];
  assign dr_data = sr_q[33:2];
  assign dr_op   = sr_q[1:0];

  assign hard_rst_req  = upd_cs & sr_q[17];
  assign dmi_reset_req = upd_cs & sr_q[16];
  assign dmi_start     = upd_dmi & ~busy & (dmistat_q == DMI_RSP_OK) & dmi_op_is_access(dr_op);

  assign dr_tdo = (sel_cs | sel_dmi) & sr_q[0];

  always_comb begin
    dtmcs_cap = {14'b0, 2'b00, 1'b0, 3'(IDLE_HINT), dmistat_q, 6'(ABITS), DTMCS_VERSION};
    op_field  = busy ? DMI_RSP_BUSY : dmistat_q;
    sr_d      = sr_q;
    if (sel_cs) begin
      if (dr_capture) begin
        sr_d = SRW'(dtmcs_cap);
      end else if (dr_shift) begin
        sr_d     = sr_q >> 1;
        sr_d[31] = TDI;
      end
    end else if (sel_dmi) begin
      if (dr_capture) begin
        sr_d = {last_addr_q, rsp_data_q, op_field};
      end else if (dr_shift) begin
        sr_d = {TDI, sr_q[SRW-1:1]};
      end
    end
  end

  always_ff @(posedge TCLK or negedge TRSTn) begin
    if (!TRSTn) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // Update and response bookkeeping; a clear from DTMCS outranks any concurrent status change.
  always_ff @(posedge TCLK or negedge TRSTn) begin
    if (!TRSTn) begin
      dmistat_q      <= DMI_RSP_OK;
      last_addr_q    <= '0;
      rsp_data_q     <= '0;
      dmi_hard_reset <= 1'b0;
    end else begin
      dmi_hard_reset <= hard_rst_req;
      if (dmi_start) last_addr_q <= dr_addr;
      if (rsp_take) rsp_data_q <= dmi_rsp_data;
      if (hard_rst_req || dmi_reset_req) begin
        dmistat_q <= DMI_RSP_OK;
      end else if (upd_dmi && busy) begin
        dmistat_q <= DMI_RSP_BUSY;
      end else if (rsp_take && (dmi_rsp_op == DMI_RSP_FAILED) && (dmistat_q == DMI_RSP_OK)) begin
        dmistat_q <= DMI_RSP_FAILED;
      end
    end
  end

  jtag_dtm_dmi_fsm #(
    .ABITS(ABITS)
  ) u_dmi_fsm (
    .TCLK          (TCLK),
    .TRSTn         (TRSTn),
    .start         (dmi_start),
    .start_addr    (dr_addr),
    .start_data    (dr_data),
    .start_op      (dr_op),
    .hard_reset    (hard_rst_req),
    .busy          (busy),
    .rsp_take      (rsp_take),
    .dmi_req_valid (dmi_req_valid),
    .dmi_req_ready (dmi_req_ready),
    .dmi_req_addr  (dmi_req_addr),
    .dmi_req_data  (dmi_req_data),
    .dmi_req_op    (dmi_req_op),
    .dmi_rsp_valid (dmi_rsp_valid)
  );

endmodule

// File: tb/tb_jtag_dtm_dr_ctrl.sv
// Scoreboard bench for jtag_dtm_dr_ctrl: scans and DMI requests are queued as expected,
// monitors compare on each Update-DR and each request handshake.
module tb_jtag_dtm_dr_ctrl;

  localparam int SRW = 41;

  logic        TCLK = 1'b0;
  logic        TRSTn;
  logic [4:0]  ir;
  logic        dr_capture, dr_shift, dr_update, TDI;
  logic        dr_tdo;
  logic        dmi_req_valid, dmi_req_ready;
  logic [6:0]  dmi_req_addr;
  logic [31:0] dmi_req_data;
  logic [1:0]  dmi_req_op;
  logic        dmi_rsp_valid;
  logic [31:0] dmi_rsp_data;
  logic [1:0]  dmi_rsp_op;
  logic        dmi_hard_reset;

  jtag_dtm_dr_ctrl dut (
    .TCLK           (TCLK),
    .TRSTn          (TRSTn),
    .ir             (ir),
    .dr_capture     (dr_capture),
    .dr_shift       (dr_shift),
    .dr_update      (dr_update),
    .TDI            (TDI),
    .dr_tdo         (dr_tdo),
    .dmi_req_valid  (dmi_req_valid),
    .dmi_req_ready  (dmi_req_ready),
    .dmi_req_addr   (dmi_req_addr),
    .dmi_req_data   (dmi_req_data),
    .dmi_req_op     (dmi_req_op),
    .dmi_rsp_valid  (dmi_rsp_valid),
    .dmi_rsp_data   (dmi_rsp_data),
    .dmi_rsp_op     (dmi_rsp_op),
    .dmi_hard_reset (dmi_hard_reset)
  );

  always #5 TCLK = ~TCLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [SRW-1:0] val;
    string          name;
  } scan_t;

  typedef struct {
    logic [6:0]  a;
    logic [31:0] d;
    logic [1:0]  op;
    int          waits;
    string       name;
  } req_t;

  scan_t exp_scan[$];
  req_t  exp_req[$];

  int          cfg_rdy_dly  = 0;
  int          cfg_rsp_dly  = 0;
  logic [31:0] cfg_rsp_data = 32'h0;
  logic [1:0]  cfg_rsp_op   = 2'd0;
  int          hr_cnt       = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [SRW-1:0] dmi(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
    return {a, d, op};
  endfunction

  // Scan monitor: assemble TDO bits shifted out, compare at Update-DR.
  logic [SRW-1:0] sh_word = '0;
  int             sh_cnt  = 0;
  always @(negedge TCLK) begin
    if (TRSTn && (ir == 5'h10 || ir == 5'h11)) begin
      if (dr_capture) begin
        sh_word = '0;
        sh_cnt  = 0;
      end else if (dr_shift) begin
        if (sh_cnt < SRW) sh_word[sh_cnt] = dr_tdo;
        sh_cnt++;
      end else if (dr_update) begin
        scan_t e;
        if (exp_scan.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scan_unexpected: got %0h expected no scan", sh_word);
        end else begin
          e = exp_scan.pop_front();
          chk(e.name, 64'(sh_word), 64'(e.val));
        end
      end
    end
  end

  // Request monitor: count stalled cycles, compare fields at the handshake.
  int wcnt = 0;
  always @(negedge TCLK) begin
    if (!dmi_req_valid) begin
      wcnt = 0;
    end else if (!dmi_req_ready) begin
      wcnt++;
    end else begin
      req_t r;
      if (exp_req.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL req_unexpected: got addr %0h data %0h op %0h expected none",
                 dmi_req_addr, dmi_req_data, dmi_req_op);
      end else begin
        r = exp_req.pop_front();
        chk({r.name, "_addr"}, 64'(dmi_req_addr), 64'(r.a));
        chk({r.name, "_data"}, 64'(dmi_req_data), 64'(r.d));
        chk({r.name, "_op"}, 64'(dmi_req_op), 64'(r.op));
        chk({r.name, "_stall"}, 64'(wcnt), 64'(r.waits));
      end
      wcnt = 0;
    end
  end

  always @(negedge TCLK) if (dmi_hard_reset) hr_cnt++;

  // Debug-module model: ready after cfg_rdy_dly cycles, response cfg_rsp_dly cycles after accept.
  initial begin
    bit hs;
    bit rsp_pend;
    int rsp_cnt;
    int rdy_cnt;
    rsp_pend = 0;
    rsp_cnt  = 0;
    rdy_cnt  = 0;
    dmi_req_ready = 1'b0;
    dmi_rsp_valid = 1'b0;
    dmi_rsp_data  = 32'h0;
    dmi_rsp_op    = 2'd0;
    forever begin
      @(negedge TCLK);
      hs = dmi_req_valid && dmi_req_ready;
      @(posedge TCLK);
      #1;
      dmi_rsp_valid = 1'b0;
      if (!TRSTn) begin
        rsp_pend = 0;
        rdy_cnt  = 0;
        dmi_req_ready = 1'b0;
      end else begin
        if (hs) begin
          dmi_req_ready = 1'b0;
          if (cfg_rsp_dly >= 0) begin
            rsp_pend = 1;
            rsp_cnt  = cfg_rsp_dly;
          end
        end
        if (rsp_pend) begin
          if (rsp_cnt == 0) begin
            dmi_rsp_valid = 1'b1;
            dmi_rsp_data  = cfg_rsp_data;
            dmi_rsp_op    = cfg_rsp_op;
            rsp_pend      = 0;
          end else begin
            rsp_cnt--;
          end
        end
        if (dmi_req_valid && !dmi_req_ready) begin
          if (rdy_cnt >= cfg_rdy_dly) dmi_req_ready = 1'b1;
          else rdy_cnt++;
        end else if (!dmi_req_valid) begin
          dmi_req_ready = 1'b0;
          rdy_cnt = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge TCLK);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic scan(input logic [4:0] irv, input int n, input logic [SRW-1:0] din,
                      input logic [SRW-1:0] expv, input string name);
    scan_t e;
    e.val  = expv;
    e.name = name;
    exp_scan.push_back(e);
    ir = irv;
    dr_capture = 1'b1;
    step();
    dr_capture = 1'b0;
    dr_shift   = 1'b1;
    for (int i = 0; i < n; i++) begin
      TDI = din[i];
      step();
    end
    dr_shift  = 1'b0;
    TDI       = 1'b0;
    dr_update = 1'b1;
    step();
    dr_update = 1'b0;
  endtask

  task automatic push_req(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op,
                          input int waits, input string name);
    req_t r;
    r.a = a; r.d = d; r.op = op; r.waits = waits; r.name = name;
    exp_req.push_back(r);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    TRSTn = 1'b0;
    ir = 5'h0;
    dr_capture = 1'b0;
    dr_shift   = 1'b0;
    dr_update  = 1'b0;
    TDI        = 1'b0;
    #12;
    chk("rst_valid", 64'(dmi_req_valid), 64'h0);
    chk("rst_addr", 64'(dmi_req_addr), 64'h0);
    chk("rst_data", 64'(dmi_req_data), 64'h0);
    chk("rst_op", 64'(dmi_req_op), 64'h0);
    chk("rst_hardreset", 64'(dmi_hard_reset), 64'h0);
    chk("rst_tdo", 64'(dr_tdo), 64'h0);
    step();
    TRSTn = 1'b1;
    step();

    // DTMCS readout after reset
    scan(5'h10, 32, '0, SRW'(32'h0000_1071), "dtmcs_reset");

    // write, ready immediately, OK response
    cfg_rdy_dly = 0; cfg_rsp_dly = 0; cfg_rsp_data = 32'hAAAA_5555; cfg_rsp_op = 2'd0;
    push_req(7'h10, 32'hDEAD_BEEF, 2'd2, 0, "req_write");
    scan(5'h11, 41, dmi(7'h10, 32'hDEAD_BEEF, 2'd2), dmi(7'h00, 32'h0, 2'd0), "dmi_first_cap");
    steps(10);

    // read with ready delayed 3 cycles
    cfg_rdy_dly = 3; cfg_rsp_dly = 2; cfg_rsp_data = 32'h1234_5678; cfg_rsp_op = 2'd0;
    push_req(7'h04, 32'h0, 2'd1, 3, "req_read");
    scan(5'h11, 41, dmi(7'h04, 32'h0, 2'd1), dmi(7'h10, 32'hAAAA_5555, 2'd0), "dmi_after_write");
    steps(20);
    scan(5'h11, 41, dmi(7'h00, 32'h0, 2'd0), dmi(7'h04, 32'h1234_5678, 2'd0), "dmi_after_read");

    // update while WAIT: busy, sticky 3, ignored until dmireset
    cfg_rdy_dly = 0; cfg_rsp_dly = 60; cfg_rsp_data = 32'h5566_7788; cfg_rsp_op = 2'd0;
    push_req(7'h22, 32'h1111_2222, 2'd2, 0, "req_long");
    scan(5'h11, 41, dmi(7'h22, 32'h1111_2222, 2'd2), dmi(7'h04, 32'h1234_5678, 2'd0), "dmi_nop_cap");
    scan(5'h11, 41, dmi(7'h33, 32'h3333_4444, 2'd2), dmi(7'h22, 32'h1234_5678, 2'd3), "dmi_busy_cap");
    steps(30);
    scan(5'h11, 41, dmi(7'h44, 32'h0000_0099, 2'd2), dmi(7'h22, 32'h5566_7788, 2'd3), "dmi_sticky_cap");
    scan(5'h10, 32, SRW'(32'h0001_0000), SRW'(32'h0000_1C71), "dtmcs_busy_stat");

    // after dmireset the next request goes out; it fails
    cfg_rsp_dly = 0; cfg_rsp_data = 32'h0BAD_F00D; cfg_rsp_op = 2'd2;
    push_req(7'h45, 32'hABCD_0123, 2'd2, 0, "req_after_clr");
    scan(5'h11, 41, dmi(7'h45, 32'hABCD_0123, 2'd2), dmi(7'h22, 32'h5566_7788, 2'd0), "dmi_cleared_cap");
    steps(10);
    scan(5'h10, 32, '0, SRW'(32'h0000_1871), "dtmcs_failed_stat");
    scan(5'h11, 41, dmi(7'h50, 32'h0, 2'd1), dmi(7'h45, 32'h0BAD_F00D, 2'd2), "dmi_failed_cap");
    steps(5);
    scan(5'h11, 41, '0, dmi(7'h45, 32'h0BAD_F00D, 2'd2), "dmi_still_failed");
    scan(5'h10, 32, SRW'(32'h0001_0000), SRW'(32'h0000_1871), "dtmcs_failed_again");
    scan(5'h10, 32, '0, SRW'(32'h0000_1071), "dtmcs_cleared");

    // dtmhardreset while REQ
    cfg_rdy_dly = 1000; cfg_rsp_dly = -1;
    scan(5'h11, 41, dmi(7'h60, 32'h0000_600D, 2'd2), dmi(7'h45, 32'h0BAD_F00D, 2'd0), "dmi_pre_hr");
    steps(2);
    chk("hr_valid_before", 64'(dmi_req_valid), 64'h1);
    scan(5'h10, 32, SRW'(32'h0002_0000), SRW'(32'h0000_1071), "dtmcs_pre_hr");
    chk("hr_pulse_high", 64'(dmi_hard_reset), 64'h1);
    chk("hr_valid_drop", 64'(dmi_req_valid), 64'h0);
    step();
    chk("hr_pulse_low", 64'(dmi_hard_reset), 64'h0);
    chk("hr_pulse_count", 64'(hr_cnt), 64'h1);
    scan(5'h11, 41, '0, dmi(7'h60, 32'h0BAD_F00D, 2'd0), "dmi_after_hr");

    // TRSTn while WAIT
    cfg_rdy_dly = 0; cfg_rsp_dly = -1;
    push_req(7'h70, 32'h0000_7777, 2'd1, 0, "req_pre_trst");
    scan(5'h11, 41, dmi(7'h70, 32'h0000_7777, 2'd1), dmi(7'h60, 32'h0BAD_F00D, 2'd0), "dmi_pre_trst");
    steps(3);
    TRSTn = 1'b0;
    #2;
    chk("trst_valid", 64'(dmi_req_valid), 64'h0);
    chk("trst_addr", 64'(dmi_req_addr), 64'h0);
    chk("trst_data", 64'(dmi_req_data), 64'h0);
    chk("trst_op", 64'(dmi_req_op), 64'h0);
    chk("trst_hardreset", 64'(dmi_hard_reset), 64'h0);
    chk("trst_tdo", 64'(dr_tdo), 64'h0);
    step();
    TRSTn = 1'b1;
    step();
    scan(5'h11, 41, '0, dmi(7'h00, 32'h0, 2'd0), "dmi_after_trst");
    scan(5'h10, 32, '0, SRW'(32'h0000_1071), "dtmcs_after_trst");
    steps(5);

    chk("scan_queue_empty", 64'(exp_scan.size()), 64'h0);
    chk("req_queue_empty", 64'(exp_req.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
